// File: rtl/decode_out_queue_pkg.sv
// Shared widths, bundle type and NOP constant for the decode-to-execute queue.
package decode_out_queue_pkg;

    localparam int unsigned IR_W_DEF     = 16;
    localparam int unsigned NPC_W_DEF    = 16;
    localparam int unsigned E_CTRL_W_DEF = 6;
    localparam int unsigned W_CTRL_W_DEF = 2;
    localparam int unsigned DEPTH_DEF    = 4;

    typedef struct packed {
        logic [IR_W_DEF-1:0]     ir;
        logic [NPC_W_DEF-1:0]    npc;
        logic [E_CTRL_W_DEF-1:0] e_control;
        logic                    mem_control;
        logic [W_CTRL_W_DEF-1:0] w_control;
    } decode_bundle_t;

    // Bubble presented to execute whenever no bundle is valid.
    localparam decode_bundle_t DECODE_NOP = '0;

    function automatic int unsigned bundle_width(input int unsigned ir_w,
                                                 input int unsigned npc_w,
                                                 input int unsigned e_w,
                                                 input int unsigned w_w);
        return ir_w + npc_w + e_w + 1 + w_w;
    endfunction

endpackage

// File: rtl/decode_out_queue_if.sv
// Decode/execute handshake bundle; master drives pushes and pops, slave is the queue.
interface decode_out_queue_if #(
    parameter int unsigned IR_W     = decode_out_queue_pkg::IR_W_DEF,
    parameter int unsigned NPC_W    = decode_out_queue_pkg::NPC_W_DEF,
    parameter int unsigned E_CTRL_W = decode_out_queue_pkg::E_CTRL_W_DEF,
    parameter int unsigned W_CTRL_W = decode_out_queue_pkg::W_CTRL_W_DEF,
    parameter int unsigned DEPTH    = decode_out_queue_pkg::DEPTH_DEF
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                enable_decode;
    logic [IR_W-1:0]     in_ir;
    logic [NPC_W-1:0]    in_npc;
    logic [E_CTRL_W-1:0] in_e_control;
    logic                in_mem_control;
    logic [W_CTRL_W-1:0] in_w_control;
    logic                in_ready;
    logic                flush;

    logic                out_valid;
    logic                out_ready;
    logic [IR_W-1:0]     ir;
    logic [NPC_W-1:0]    npc_out;
    logic [E_CTRL_W-1:0] e_control;
    logic                mem_control;
    logic [W_CTRL_W-1:0] w_control;
    logic [CW-1:0]       count;

    modport master (
        output enable_decode, in_ir, in_npc, in_e_control, in_mem_control,
               in_w_control, flush, out_ready,
        input  in_ready, out_valid, ir, npc_out, e_control, mem_control,
               w_control, count
    );

    modport slave (
        input  enable_decode, in_ir, in_npc, in_e_control, in_mem_control,
               in_w_control, flush, out_ready,
        output in_ready, out_valid, ir, npc_out, e_control, mem_control,
               w_control, count
    );

endinterface

// File: rtl/decode_out_queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module decode_out_queue_mem #(
    parameter  int unsigned WIDTH = 41,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] store [DEPTH];

    // Contents are deliberately left uninitialised; count/valid gate every read.
    always_ff @(posedge clock) begin
        if (we) begin
            store[waddr] <= wdata;
        end
    end

    assign rdata = store[raddr];

endmodule

// File: rtl/decode_out_queue.sv
// Decode-to-execute FIFO with valid/ready handshake and NOP masking on empty.
// Optional same-cycle bypass when empty: define DECODE_OUT_QUEUE_BYPASS_EN.
module decode_out_queue
    import decode_out_queue_pkg::*;
#(
    parameter int unsigned IR_W     = IR_W_DEF,
    parameter int unsigned NPC_W    = NPC_W_DEF,
    parameter int unsigned E_CTRL_W = E_CTRL_W_DEF,
    parameter int unsigned W_CTRL_W = W_CTRL_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF
) (
    input  logic               clock,
    input  logic               reset,
    decode_out_queue_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = bundle_width(IR_W, NPC_W, E_CTRL_W, W_CTRL_W);

    typedef struct packed {
        logic [IR_W-1:0]     ir;
        logic [NPC_W-1:0]    npc;
        logic [E_CTRL_W-1:0] e_control;
        logic                mem_control;
        logic [W_CTRL_W-1:0] w_control;
    } bundle_t;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    bundle_t       in_bundle;
    bundle_t       rd_bundle;
    bundle_t       head;
    logic [BW-1:0] rd_data;

    logic empty;
    logic full;
    logic clear;
    logic push;
    logic pop;
    logic head_valid;

    assign in_bundle = '{
        ir:          bus.in_ir,
        npc:         bus.in_npc,
        e_control:   bus.in_e_control,
        mem_control: bus.in_mem_control,
        w_control:   bus.in_w_control
    };

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    // Reset and flush share one path: a mid-run reset is just a forced flush.
    assign clear = reset || bus.flush;

`ifdef DECODE_OUT_QUEUE_BYPASS_EN
    logic bypass;
    logic bypass_take;

    assign bypass      = empty && bus.enable_decode && !clear;
    assign bypass_take = bypass && bus.out_ready;
    assign push        = bus.enable_decode && !full && !bypass_take;
    assign head_valid  = !empty || bypass;
    assign head        = empty ? in_bundle : rd_bundle;
`else
    assign push        = bus.enable_decode && !full;
    assign head_valid  = !empty;
    assign head        = rd_bundle;
`endif

    assign pop = !empty && bus.out_ready;

    // Pointer and occupancy state; full refuses push even alongside a pop.
    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    decode_out_queue_mem #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (push && !clear),
        .waddr (wr_ptr),
        .wdata (BW'(in_bundle)),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign rd_bundle = bundle_t'(rd_data);

    assign bus.in_ready    = !full;
    assign bus.out_valid   = head_valid;
    assign bus.count       = cnt;

    // Execute sees an all-zero NOP bundle whenever the head is not valid.
    assign bus.ir          = head_valid ? head.ir          : IR_W'(DECODE_NOP.ir);
    assign bus.npc_out     = head_valid ? head.npc         : NPC_W'(DECODE_NOP.npc);
    assign bus.e_control   = head_valid ? head.e_control   : E_CTRL_W'(DECODE_NOP.e_control);
    assign bus.mem_control = head_valid ? head.mem_control : DECODE_NOP.mem_control;
    assign bus.w_control   = head_valid ? head.w_control   : W_CTRL_W'(DECODE_NOP.w_control);

endmodule

// File: tb/tb_decode_out_queue.sv
// Randomised and directed bench for decode_out_queue against a queue-based reference model.
module tb_decode_out_queue;
    import decode_out_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clock;
    logic reset;

    decode_out_queue_if #(.DEPTH(DEPTH)) bus ();

    decode_out_queue #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    decode_bundle_t mq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic decode_bundle_t mk(input logic [15:0] ir_v, input logic [15:0] npc_v);
        decode_bundle_t b;
        b.ir          = ir_v;
        b.npc         = npc_v;
        b.e_control   = 6'(ir_v[5:0] ^ 6'h15);
        b.mem_control = ir_v[0];
        b.w_control   = 2'(ir_v[3:2]);
        return b;
    endfunction

    // One clock: drive, check visible outputs at negedge, advance model, cross posedge.
    task automatic step(input logic en, input decode_bundle_t b, input logic fl,
                        input logic ordy, input logic rst);
        int sz;
        logic byp;
        logic take;
        logic exp_valid;
        decode_bundle_t exp_b;
        bus.enable_decode  = en;
        bus.in_ir          = b.ir;
        bus.in_npc         = b.npc;
        bus.in_e_control   = b.e_control;
        bus.in_mem_control = b.mem_control;
        bus.in_w_control   = b.w_control;
        bus.flush          = fl;
        bus.out_ready      = ordy;
        reset              = rst;
        @(negedge clock);
        sz  = mq.size();
        byp = 1'b0;
`ifdef DECODE_OUT_QUEUE_BYPASS_EN
        byp = (sz == 0) && en && !fl && !rst;
`endif
        exp_valid = (sz != 0) || byp;
        if (sz != 0)  exp_b = mq[0];
        else if (byp) exp_b = b;
        else          exp_b = '0;
        check("count",       32'(bus.count),       32'(sz));
        check("in_ready",    32'(bus.in_ready),    32'(sz != DEPTH));
        check("out_valid",   32'(bus.out_valid),   32'(exp_valid));
        check("ir",          32'(bus.ir),          32'(exp_b.ir));
        check("npc_out",     32'(bus.npc_out),     32'(exp_b.npc));
        check("e_control",   32'(bus.e_control),   32'(exp_b.e_control));
        check("mem_control", 32'(bus.mem_control), 32'(exp_b.mem_control));
        check("w_control",   32'(bus.w_control),   32'(exp_b.w_control));
        if (rst || fl) begin
            mq.delete();
        end else begin
            take = byp && ordy;
            if ((sz != 0) && ordy) void'(mq.pop_front());
            if (en && (sz < DEPTH) && !take) mq.push_back(b);
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, 1'b0, ordy, 1'b0);
    endtask

    task automatic push(input logic [15:0] ir_v, input logic ordy);
        step(1'b1, mk(ir_v, ir_v + 16'h1000), 1'b0, ordy, 1'b0);
    endtask

    initial begin
        decode_bundle_t rb;
        logic r_en, r_fl, r_rd, r_rst;

        bus.enable_decode  = 1'b0;
        bus.in_ir          = '0;
        bus.in_npc         = '0;
        bus.in_e_control   = '0;
        bus.in_mem_control = 1'b0;
        bus.in_w_control   = '0;
        bus.flush          = 1'b0;
        bus.out_ready      = 1'b0;
        reset              = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state with idle inputs.
        idle(1'b0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);

        // Single push then pop.
        step(1'b1, mk(16'h1234, 16'h3001), 1'b0, 1'b0, 1'b0);
        check("single_ir",    32'(bus.ir),      32'h1234);
        check("single_npc",   32'(bus.npc_out), 32'h3001);
        check("single_count", 32'(bus.count),   32'd1);
        idle(1'b1);
        check("pop_count", 32'(bus.count),     32'd0);
        check("pop_valid", 32'(bus.out_valid), 32'd0);
        check("pop_ir",    32'(bus.ir),        32'd0);

        // Fill to DEPTH, drop a fifth push, drain across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) push(16'hA000 + 16'(i), 1'b0);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        push(16'hA004, 1'b0);
        check("full_count", 32'(bus.count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_ir", 32'(bus.ir), 32'(16'hA000 + 16'(i)));
            idle(1'b1);
        end
        check("drain_count", 32'(bus.count), 32'd0);

        // Simultaneous push and pop at count=2.
        push(16'hC000, 1'b0);
        push(16'hC001, 1'b0);
        push(16'hC002, 1'b1);
        check("pp_count", 32'(bus.count), 32'd2);
        check("pp_head",  32'(bus.ir),    32'hC001);
        idle(1'b1);
        idle(1'b1);

        // Flush at count=3 beats a concurrent push.
        for (int i = 0; i < 3; i++) push(16'hD000 + 16'(i), 1'b0);
        step(1'b1, mk(16'hBEEF, 16'h0BEE), 1'b1, 1'b0, 1'b0);
        check("flush_count", 32'(bus.count),     32'd0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        idle(1'b1);
        idle(1'b1);

        // Push into an empty queue with out_ready high.
        step(1'b1, mk(16'h5555, 16'h3100), 1'b0, 1'b1, 1'b0);
`ifdef DECODE_OUT_QUEUE_BYPASS_EN
        check("bypass_count", 32'(bus.count), 32'd0);
`else
        check("nobyp_count", 32'(bus.count), 32'd1);
        check("nobyp_ir",    32'(bus.ir),    32'h5555);
`endif
        idle(1'b1);

        // Randomised traffic with occasional flush and reset.
        for (int n = 0; n < 3000; n++) begin
            rb.ir          = 16'($urandom);
            rb.npc         = 16'($urandom);
            rb.e_control   = 6'($urandom);
            rb.mem_control = 1'($urandom);
            rb.w_control   = 2'($urandom);
            r_en  = ($urandom_range(0, 99) < 60);
            r_rd  = ($urandom_range(0, 99) < 50);
            r_fl  = ($urandom_range(0, 99) < 3);
            r_rst = ($urandom_range(0, 99) < 1);
            step(r_en, rb, r_fl, r_rd, r_rst);
        end
        repeat (DEPTH + 1) idle(1'b1);
        check("final_count", 32'(bus.count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_out_queue.md
# decode_out_queue

Parametrised decode-to-execute buffer for the LC-3 pipeline, replacing the single decode output register with a DEPTH-entry FIFO and a valid/ready handshake. The decode stage writes one decoded instruction bundle (IR, NPC, execute/memory/writeback controls) per `enable_decode` pulse. The execute stage drains bundles with `out_ready`. When no bundle is valid, every control output reads zero, so execute sees a NOP bubble.

## Interface
- `IR_W`, 16, instruction register width
- `NPC_W`, 16, next-PC width
- `E_CTRL_W`, 6, execute control width
- `W_CTRL_W`, 2, writeback control width
- `DEPTH`, 4, entries; power of two, at least 2
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `enable_decode`  in  1  push request from decode
- `in_ir`  in  IR_W  IR to enqueue
- `in_npc`  in  NPC_W  NPC to enqueue
- `in_e_control`  in  E_CTRL_W  execute control to enqueue
- `in_mem_control`  in  1  memory control to enqueue
- `in_w_control`  in  W_CTRL_W  writeback control to enqueue
- `in_ready`  out  1  queue can accept a push (not full)
- `flush`  in  1  discard all entries (branch redirect)
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  execute consumes head
- `ir`  out  IR_W  head IR
- `npc_out`  out  NPC_W  head NPC
- `e_control`  out  E_CTRL_W  head execute control
- `mem_control`  out  1  head memory control
- `w_control`  out  W_CTRL_W  head writeback control
- `count`  out  $clog2(DEPTH)+1  occupancy

## Operation
- Push accepted = `enable_decode && in_ready`. The bundle is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- Pop = `out_valid && out_ready`. `rd_ptr` increments modulo DEPTH.
- `in_ready = (count != DEPTH)`.
  - When full, a push is refused even if a pop occurs in the same cycle; no full-through.
  - A push with `in_ready=0` is dropped. Decode must hold the bundle and retry.
- `out_valid = (count != 0)`.
- Data outputs show the entry at `rd_ptr` when `out_valid=1`. They are forced to all-zero when `out_valid=0`.
- Simultaneous push and pop when neither full nor empty: `count` is unchanged and both pointers advance.
- `flush` has priority over push and pop. The next cycle has `count=0`, both pointers at 0, and `out_valid=0`. A push in the flush cycle is discarded.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally; `count` disambiguates full from empty.

## Timing
- Reset values: `count=0`, `in_ready=1`, `out_valid=0`, all data outputs 0, pointers 0. Storage contents are not cleared.
- Reset mid-operation behaves exactly like `flush`. In-flight entries are lost.
- Latency without bypass: a push in cycle N is visible on the outputs in cycle N+1.
- `in_ready`, `out_valid` and `count` are registered-state functions, except in bypass (see Configuration).
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.

## Configuration
- `DECODE_OUT_QUEUE_BYPASS_EN` defined: when `count=0`, `enable_decode=1` and `flush=0`:
  - `out_valid` is asserted combinationally and the `in_*` bundle appears on the outputs the same cycle.
  - If `out_ready=1`, the bundle is consumed without being written; `count` stays 0 and the pointers do not move.
  - If `out_ready=0`, it is enqueued normally.
- Not defined: there is no combinational path from the `in_*` inputs to the outputs, and minimum latency is 1 cycle.

## Structure
- Package `decode_out_queue_pkg` holds:
  - default width constants (`IR_W_DEF`, `NPC_W_DEF`, `E_CTRL_W_DEF`, `W_CTRL_W_DEF`);
  - the packed struct `decode_bundle_t` {ir, npc, e_control, mem_control, w_control};
  - the all-zero constant `DECODE_NOP` used for output masking.
- Sub-module `decode_out_queue_mem`: a DEPTH x bundle register array with one write port and one asynchronous read port. Pointer, count and handshake logic stay in the top.

## Test plan
- Reset, then idle: `count=0`, `in_ready=1`, `out_valid=0`, `ir`/`e_control`/`w_control`/`mem_control`/`npc_out` all 0.
- Push IR 0x1234 / NPC 0x3001 with `out_ready=0` -> next cycle `out_valid=1`, `ir=0x1234`, `npc_out=0x3001`, `count=1`. Pop -> `count=0`, outputs 0.
- Fill with DEPTH=4 pushes (IR 0xA000..0xA003) while `out_ready=0`:
  - `in_ready=0` after the 4th push, and a 5th push (0xA004) is dropped;
  - drain yields 0xA000..0xA003 in order across pointer wrap.
- With `count=2`, push and pop in the same cycle -> `count` stays 2, and the next head is the 2nd entry.
- With `count=3`, assert `flush` together with a push of 0xBEEF -> next cycle `count=0`, `out_valid=0`; 0xBEEF never appears.
- With `DECODE_OUT_QUEUE_BYPASS_EN`, empty queue, push 0x5555 with `out_ready=1` -> same cycle `out_valid=1`, `ir=0x5555`; next cycle `count=0`. Without the macro, `ir=0x5555` appears one cycle later.
